// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing FSM for the multicycle RV32I core. It decodes the latched
//   instruction fields and steers the shared ALU, register file, instruction
//   register and unified memory port over several cycles per instruction.
//   Unsupported encodings park the controller in TRAP until reset.
//
// Ports
//   clock, reset_n      rising-edge clock, async active-low reset
//   opcode/funct3/funct7b5  instruction register fields
//   zero                ALU zero flag (combinational)
//   mem_ready           memory completes the current read/write this cycle
//   PC_write, IR_write, reg_write, mem_read, mem_write   enables / requests
//   address_select, result_select, ALU_select_A/B, immediate_select,
//   ALU_control         datapath steering
//   illegal             high while in TRAP
//   state               current state code (debug)
module multicycle_controller (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       IR_write,
    output logic       address_select,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_select,
    output logic [1:0] ALU_select_A,
    output logic [1:0] ALU_select_B,
    output logic [1:0] immediate_select,
    output logic [2:0] ALU_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t r_state;
    state_t w_next;
    logic   w_pc_write;
    logic   w_ir_write;
    logic   w_mem_read;
    logic   w_mem_write;
    logic   w_reg_write;
    logic   w_illegal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        w_pc_write       = 1'b0;
        w_ir_write       = 1'b0;
        w_mem_read       = 1'b0;
        w_mem_write      = 1'b0;
        w_reg_write      = 1'b0;
        w_illegal        = 1'b0;
        address_select   = 1'b0;
        result_select    = 2'b00;
        ALU_select_A     = 2'b00;
        ALU_select_B     = 2'b00;
        immediate_select = 2'b00;
        ALU_control      = ALU_ADD;

        unique case (r_state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR latches.
                w_mem_read    = 1'b1;
                ALU_select_B  = 2'b10;
                result_select = 2'b10;
                w_ir_write    = mem_ready;
                w_pc_write    = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute old_PC+imm so BRANCH/JAL find the target in ALU_out.
                ALU_select_A = 2'b01;
                ALU_select_B = 2'b01;
                case (opcode)
                    OP_SW:   immediate_select = 2'b01;
                    OP_BEQ:  immediate_select = 2'b10;
                    OP_JAL:  immediate_select = 2'b11;
                    default: immediate_select = 2'b00;
                endcase
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_R:         w_next = S_EXECUTE_R;
                    OP_I:         w_next = S_EXECUTE_I;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                // Only lw/sw reach here; opcode[5] tells them apart.
                ALU_select_A     = 2'b10;
                ALU_select_B     = 2'b01;
                immediate_select = {1'b0, opcode[5]};
                w_next           = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                address_select = 1'b1;
                w_mem_read     = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_select = 2'b01;
                w_reg_write   = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEM_WRITE: begin
                address_select = 1'b1;
                w_mem_write    = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECUTE_R, S_EXECUTE_I: begin
                ALU_select_A = 2'b10;
                ALU_select_B = (r_state == S_EXECUTE_R) ? 2'b00 : 2'b01;
                w_next       = S_ALU_WB;
                case (funct3)
                    3'b000:  ALU_control = (r_state == S_EXECUTE_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALU_control = ALU_SLT;
                    3'b110:  ALU_control = ALU_OR;
                    3'b111:  ALU_control = ALU_AND;
                    default: w_next      = S_TRAP;
                endcase
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                // Compare rs1-rs2; target was parked in ALU_out during DECODE.
                ALU_select_A = 2'b10;
                ALU_control  = ALU_SUB;
                if (funct3 == 3'b000) begin
                    w_pc_write = zero;
                    w_next     = S_FETCH;
                end else begin
                    w_next     = S_TRAP;
                end
            end
            S_JAL: begin
                // PC <= target from ALU_out; ALU_result = old_PC+4 is kept for rd.
                ALU_select_A = 2'b01;
                ALU_select_B = 2'b10;
                w_pc_write   = 1'b1;
                w_next       = S_ALU_WB;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Reset blanks every side-effecting output even though the state already
    // reads FETCH, so a held reset with mem_ready high writes nothing.
    assign PC_write  = reset_n & w_pc_write;
    assign IR_write  = reset_n & w_ir_write;
    assign mem_read  = reset_n & w_mem_read;
    assign mem_write = reset_n & w_mem_write;
    assign reg_write = reset_n & w_reg_write;
    assign illegal   = reset_n & w_illegal;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed, table-driven bench for multicycle_controller. Each table row is
//   one clock cycle: inputs applied after the falling edge, the full output
//   word compared shortly after. Hand-written sequences cover traps and a
//   reset pulse in the middle of a store.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic       clock;
    logic       reset_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PC_write, IR_write, address_select, mem_read, mem_write, reg_write;
    logic [1:0] result_select, ALU_select_A, ALU_select_B, immediate_select;
    logic [2:0] ALU_control;
    logic       illegal;
    logic [3:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_controller dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7b5         (funct7b5),
        .zero             (zero),
        .mem_ready        (mem_ready),
        .PC_write         (PC_write),
        .IR_write         (IR_write),
        .address_select   (address_select),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .reg_write        (reg_write),
        .result_select    (result_select),
        .ALU_select_A     (ALU_select_A),
        .ALU_select_B     (ALU_select_B),
        .immediate_select (immediate_select),
        .ALU_control      (ALU_control),
        .illegal          (illegal),
        .state            (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [21:0] exp;
        string       nm;
    } vec_t;

    // Expected output word:
    // {state, PC_write, IR_write, address_select, mem_read, mem_write,
    //  reg_write, result_select, ALU_select_A, ALU_select_B,
    //  immediate_select, ALU_control, illegal}
    function automatic logic [21:0] E(int st, int pcw, int irw, int asel, int mrd,
                                      int mwr, int rw, int rsel, int sa, int sb,
                                      int imm, int alu, int ill);
        return {st[3:0], pcw[0], irw[0], asel[0], mrd[0], mwr[0], rw[0],
                rsel[1:0], sa[1:0], sb[1:0], imm[1:0], alu[2:0], ill[0]};
    endfunction

    function automatic vec_t V(logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                               logic mr, logic [21:0] exp, string nm);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    function automatic logic [21:0] actual();
        return {state, PC_write, IR_write, address_select, mem_read, mem_write,
                reg_write, result_select, ALU_select_A, ALU_select_B,
                immediate_select, ALU_control, illegal};
    endfunction

    task automatic chk(string nm, logic [21:0] exp);
        logic [21:0] a;
        a = actual();
        n_vec++;
        if (a !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0t: got state=%0d word=%b, want state=%0d word=%b",
                     nm, $time, a[21:18], a, exp[21:18], exp);
        end
    endtask

    // One cycle: drive after the falling edge (reset released), compare 1 ns later.
    task automatic step(logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic mr,
                        logic [21:0] exp, string nm);
        @(negedge clock);
        reset_n   = 1'b1;
        opcode    = op;
        funct3    = f3;
        funct7b5  = f7;
        zero      = z;
        mem_ready = mr;
        #1;
        chk(nm, exp);
    endtask

    logic [21:0] RST, F1, F0, WB, TRP;

    task automatic do_reset(string nm);
        @(negedge clock);
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk({nm, "_rst_a"}, RST);
        @(negedge clock);
        #1;
        chk({nm, "_rst_b"}, RST);
    endtask

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0; opcode = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;

        RST = E(0, 0,0,0,0,0,0, 2,0,2,0,0, 0);
        F1  = E(0, 1,1,0,1,0,0, 2,0,2,0,0, 0);
        F0  = E(0, 0,0,0,1,0,0, 2,0,2,0,0, 0);
        WB  = E(8, 0,0,0,0,0,1, 0,0,0,0,0, 0);
        TRP = E(15,0,0,0,0,0,0, 0,0,0,0,0, 1);

        // add
        tbl.push_back(V(OP_R, 3'b000, 0, 0, 1, F1, "add_f"));
        tbl.push_back(V(OP_R, 3'b000, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "add_d"));
        tbl.push_back(V(OP_R, 3'b000, 0, 0, 1, E(6,0,0,0,0,0,0,0,2,0,0,0,0), "add_x"));
        tbl.push_back(V(OP_R, 3'b000, 0, 0, 1, WB, "add_wb"));
        // sub
        tbl.push_back(V(OP_R, 3'b000, 1, 0, 1, F1, "sub_f"));
        tbl.push_back(V(OP_R, 3'b000, 1, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "sub_d"));
        tbl.push_back(V(OP_R, 3'b000, 1, 0, 1, E(6,0,0,0,0,0,0,0,2,0,0,1,0), "sub_x"));
        tbl.push_back(V(OP_R, 3'b000, 1, 0, 1, WB, "sub_wb"));
        // and (R)
        tbl.push_back(V(OP_R, 3'b111, 0, 0, 1, F1, "and_f"));
        tbl.push_back(V(OP_R, 3'b111, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "and_d"));
        tbl.push_back(V(OP_R, 3'b111, 0, 0, 1, E(6,0,0,0,0,0,0,0,2,0,0,2,0), "and_x"));
        tbl.push_back(V(OP_R, 3'b111, 0, 0, 1, WB, "and_wb"));
        // addi with funct7b5=1 must still add
        tbl.push_back(V(OP_I, 3'b000, 1, 0, 1, F1, "addi_f"));
        tbl.push_back(V(OP_I, 3'b000, 1, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "addi_d"));
        tbl.push_back(V(OP_I, 3'b000, 1, 0, 1, E(7,0,0,0,0,0,0,0,2,1,0,0,0), "addi_x"));
        tbl.push_back(V(OP_I, 3'b000, 1, 0, 1, WB, "addi_wb"));
        // slti
        tbl.push_back(V(OP_I, 3'b010, 0, 0, 1, F1, "slti_f"));
        tbl.push_back(V(OP_I, 3'b010, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "slti_d"));
        tbl.push_back(V(OP_I, 3'b010, 0, 0, 1, E(7,0,0,0,0,0,0,0,2,1,0,5,0), "slti_x"));
        tbl.push_back(V(OP_I, 3'b010, 0, 0, 1, WB, "slti_wb"));
        // ori
        tbl.push_back(V(OP_I, 3'b110, 0, 0, 1, F1, "ori_f"));
        tbl.push_back(V(OP_I, 3'b110, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "ori_d"));
        tbl.push_back(V(OP_I, 3'b110, 0, 0, 1, E(7,0,0,0,0,0,0,0,2,1,0,3,0), "ori_x"));
        tbl.push_back(V(OP_I, 3'b110, 0, 0, 1, WB, "ori_wb"));
        // lw with three wait cycles in MEM_READ: 8 cycles total
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 1, F1, "lw_f"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "lw_d"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 1, E(2,0,0,0,0,0,0,0,2,1,0,0,0), "lw_a"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 0, E(3,0,0,1,1,0,0,0,0,0,0,0,0), "lw_r0"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 0, E(3,0,0,1,1,0,0,0,0,0,0,0,0), "lw_r1"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 0, E(3,0,0,1,1,0,0,0,0,0,0,0,0), "lw_r2"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 1, E(3,0,0,1,1,0,0,0,0,0,0,0,0), "lw_r3"));
        tbl.push_back(V(OP_LW, 3'b010, 0, 0, 1, E(4,0,0,0,0,0,1,1,0,0,0,0,0), "lw_wb"));
        // sw with one FETCH stall and one MEM_WRITE stall
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 0, F0, "sw_f0"));
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 1, F1, "sw_f1"));
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,1,0,0), "sw_d"));
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 1, E(2,0,0,0,0,0,0,0,2,1,1,0,0), "sw_a"));
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 0, E(5,0,0,1,0,1,0,0,0,0,0,0,0), "sw_w0"));
        tbl.push_back(V(OP_SW, 3'b010, 0, 0, 1, E(5,0,0,1,0,1,0,0,0,0,0,0,0), "sw_w1"));
        // beq taken / not taken
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 1, 1, F1, "beqt_f"));
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 1, 1, E(1,0,0,0,0,0,0,0,1,1,2,0,0), "beqt_d"));
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 1, 1, E(9,1,0,0,0,0,0,0,2,0,0,1,0), "beqt_b"));
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 0, 1, F1, "beqn_f"));
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,2,0,0), "beqn_d"));
        tbl.push_back(V(OP_BEQ, 3'b000, 0, 0, 1, E(9,0,0,0,0,0,0,0,2,0,0,1,0), "beqn_b"));
        // jal, then back to FETCH
        tbl.push_back(V(OP_JAL, 3'b000, 0, 0, 1, F1, "jal_f"));
        tbl.push_back(V(OP_JAL, 3'b000, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,3,0,0), "jal_d"));
        tbl.push_back(V(OP_JAL, 3'b000, 0, 0, 1, E(10,1,0,0,0,0,0,0,1,2,0,0,0), "jal_j"));
        tbl.push_back(V(OP_JAL, 3'b000, 0, 0, 1, WB, "jal_wb"));
        tbl.push_back(V(OP_R, 3'b000, 0, 0, 0, F0, "end_f"));

        do_reset("init");
        foreach (tbl[i]) step(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr,
                              tbl[i].exp, tbl[i].nm);

        // Unsupported opcode: TRAP holds with no writes regardless of inputs.
        do_reset("sys");
        step(OP_SYS, 3'b000, 0, 0, 1, F1, "sys_f");
        step(OP_SYS, 3'b000, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "sys_d");
        for (int i = 0; i < 10; i++)
            step(OP_SYS, 3'(i), 1'(i), 1'b1, 1'(i), TRP, "sys_trap");

        // R-type with unsupported funct3.
        do_reset("rf3");
        step(OP_R, 3'b001, 0, 0, 1, F1, "rf3_f");
        step(OP_R, 3'b001, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,0,0,0), "rf3_d");
        step(OP_R, 3'b001, 0, 0, 1, E(6,0,0,0,0,0,0,0,2,0,0,0,0), "rf3_x");
        for (int i = 0; i < 10; i++)
            step(OP_R, 3'b001, 0, 1'b1, 1'(i), TRP, "rf3_trap");

        // Branch with funct3 != 000: never writes PC, then traps.
        do_reset("bf3");
        step(OP_BEQ, 3'b001, 0, 1, 1, F1, "bf3_f");
        step(OP_BEQ, 3'b001, 0, 1, 1, E(1,0,0,0,0,0,0,0,1,1,2,0,0), "bf3_d");
        step(OP_BEQ, 3'b001, 0, 1, 1, E(9,0,0,0,0,0,0,0,2,0,0,1,0), "bf3_b");
        step(OP_BEQ, 3'b001, 0, 1, 1, TRP, "bf3_trap");

        // Reset pulse while a store is waiting: FETCH immediately, request dropped.
        do_reset("swr");
        step(OP_SW, 3'b010, 0, 0, 1, F1, "swr_f");
        step(OP_SW, 3'b010, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,1,0,0), "swr_d");
        step(OP_SW, 3'b010, 0, 0, 1, E(2,0,0,0,0,0,0,0,2,1,1,0,0), "swr_a");
        step(OP_SW, 3'b010, 0, 0, 0, E(5,0,0,1,0,1,0,0,0,0,0,0,0), "swr_w");
        #2;
        reset_n = 1'b0;
        #1;
        chk("swr_async", RST);
        step(OP_SW, 3'b010, 0, 0, 1, F1, "swr_refetch");
        step(OP_SW, 3'b010, 0, 0, 1, E(1,0,0,0,0,0,0,0,1,1,1,0,0), "swr_redecode");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
